rr_arbiter_n: RTL and testbench
===============================

# rr_arbiter_n

Parametrised N-channel arbiter with a registered one-hot grant, selectable fixed-priority or round-robin mode, and grant hold with a bounded tenure. It is the sequential successor to the 16-bit combinational left arbiter. It sits between N requesters and one shared resource, such as the ALU result bus. In fixed mode the highest-index request wins, which matches left-arbiter priority. In round-robin mode priority rotates so that no requester can starve.

## Interface
- `N`, default 16: number of request channels, 2..32.
- `MAX_HOLD`, default 4: maximum consecutive cycles one grant may be held while others wait. 0 means unlimited hold.
- `IW`, default $clog2(N): width of `grant_idx`.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, N: request vector; bit i is channel i.
- `rr_en`, in, 1: mode select. 1 = round-robin, 0 = fixed priority with MSB highest.
- `grant`, out, N: registered one-hot grant, or all zeros.
- `grant_valid`, out, 1: high when `grant` is nonzero.
- `grant_idx`, out, IW: index of the granted channel; 0 when `grant_valid` is 0.

## Operation
**State.** Internal registers:
- FSM: IDLE or BUSY.
- `ptr` (IW bits): index of the last grantee.
- `hold_cnt`: counts 0..MAX_HOLD-1.

**IDLE.**
- If `req` == 0: stay in IDLE.
- Otherwise: arbitrate, go to BUSY, set `hold_cnt` = 0, and set `ptr` = winner.

**BUSY with grantee g.**
- `req[g]` == 0: release. If other requests are pending, arbitrate among them on the same edge and stay in BUSY with the new winner. If none are pending, go to IDLE.
- `req[g]` == 1, and either MAX_HOLD == 0 or `hold_cnt` < MAX_HOLD-1: keep g and increment `hold_cnt`.
- `req[g]` == 1 and `hold_cnt` == MAX_HOLD-1: tenure has expired.
  - If any other `req` bit is set, arbitrate with bit g masked out.
  - Otherwise keep g and reset `hold_cnt` to 0.

**Arbitration among a candidate set.**
- Fixed mode (`rr_en`=0): the highest set index wins. `ptr` is still updated.
- Round-robin mode (`rr_en`=1): search order is ptr-1, ptr-2, …, 0, N-1, …, ptr, wrapping from 0 to N-1. The first set bit wins.
  - After reset `ptr` = 0, so the first round-robin search starts at N-1. This is identical to fixed mode.

**Other rules.**
- `rr_en` is sampled only on edges where arbitration occurs. Toggling it mid-tenure has no effect on the current grant.
- `grant`, `grant_valid` and `grant_idx` are all driven from registers. No combinational path runs from `req` to any output.
- Invariant: `grant` is one-hot or zero. Any granted bit is set in the `req` sampled on the edge that issued it.

## Timing
- **Reset** (`rst_n` low, asynchronous, any time including mid-tenure):
  - `grant` = 0, `grant_valid` = 0, `grant_idx` = 0.
  - `ptr` = 0, `hold_cnt` = 0, state = IDLE.
  - Release of reset is synchronous to `clk`. The first grant can appear on the first rising edge after `rst_n` goes high.
- **Latency:** `req` sampled at edge k gives `grant` valid after edge k, i.e. 1 cycle.
- **Release latency:** if the grantee drops `req` before edge k, `grant` changes after edge k. Handover to the next requester costs zero idle cycles.
- **Tenure:** a waiting requester receives the grant at most MAX_HOLD cycles after the current grant began, when MAX_HOLD > 0. In round-robin mode, the worst-case wait is (N-1)·MAX_HOLD cycles.
- **Simultaneous events:** on an expiry edge, release by the grantee and arrival of new requests are resolved in a single arbitration, with g masked out.

## Test plan
Benches run with N=4 and MAX_HOLD=3 unless stated otherwise.
1. **Reset and idle:** assert `rst_n`=0 mid-grant → all outputs 0 immediately, without waiting for a clock edge. Release reset with `req`=0000 → outputs stay 0.
2. **Fixed priority:** `rr_en`=0, `req`=0110 → `grant`=0100, `grant_idx`=2 after 1 edge. Then drop bit 2 → `grant`=0010 on the next edge.
3. **Round-robin rotation:** `rr_en`=1, `req`=1111 held, MAX_HOLD=1 → grants 1000, 0100, 0010, 0001, 1000 on consecutive cycles.
4. **Hold expiry:** `req`=1001 held, `rr_en`=1 → `grant`=1000 for exactly 3 cycles, then 0001 for 3 cycles, then 1000 again. With `req`=1000 alone → 1000 held indefinitely.
5. **Unlimited hold and mode switch:** MAX_HOLD=0, `req`=0011 → 0010 held for 20 cycles. Toggle `rr_en` mid-tenure → no change. Drop bit 1 → 0001 on the next edge.
6. **Randomised check:** 10k cycles with a reference model → grant is always one-hot or zero, and no waiting requester exceeds (N-1)·MAX_HOLD cycles in round-robin mode.

Source files
------------

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n
//   N-channel arbiter with a registered one-hot grant. Selectable fixed
//   priority (highest index wins) or round-robin (priority rotates away from
//   the last grantee). A grantee keeps the grant while it requests, but for
//   no more than MAX_HOLD consecutive cycles while anyone else is waiting.
//
// Parameters
//   N        : number of request channels (2..32)
//   MAX_HOLD : longest tenure in cycles while others wait; 0 = unlimited
//   IW       : width of grant_idx
//
// Ports
//   clk         in   clock; all state changes on the rising edge
//   rst_n       in   asynchronous active-low reset
//   req         in   [N]  request vector, bit i = channel i
//   rr_en       in   1 = round-robin, 0 = fixed priority (MSB highest)
//   grant       out  [N]  registered one-hot grant, or zero
//   grant_valid out  high when grant is nonzero
//   grant_idx   out  [IW] index of the granted channel, 0 when idle
module rr_arbiter_n #(
    parameter int N        = 16,
    parameter int MAX_HOLD = 4,
    parameter int IW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          rr_en,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            valid_q, valid_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [N-1:0]    arb_cand;
    logic [N-1:0]    below_ptr;
    logic [N-1:0]    lo_cand;
    logic [IW-1:0]   arb_idx;
    logic            hold_expired;

    // Highest set index of a vector (0 if empty).
    function automatic logic [IW-1:0] msb_idx(input logic [N-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                r = IW'(i);
            end
        end
        return r;
    endfunction

    // Candidates are every requester except the current grantee. In IDLE the
    // grant is zero, and on a release the grantee's request is already low,
    // so this one expression covers every arbitration case, including the
    // masked arbitration on tenure expiry.
    assign arb_cand = req & ~grant_q;

    // Round-robin order ptr-1, ..., 0, N-1, ..., ptr is equivalent to:
    // highest candidate below ptr if there is one, else the highest overall.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_below
            assign below_ptr[gi] = (IW'(gi) < ptr_q);
        end
    endgenerate

    assign lo_cand = arb_cand & below_ptr;
    assign arb_idx = (rr_en && (|lo_cand)) ? msb_idx(lo_cand) : msb_idx(arb_cand);

    generate
        if (MAX_HOLD > 0) begin : g_limited
            assign hold_expired = (hold_q == HW'(MAX_HOLD - 1));
        end else begin : g_unlimited
            assign hold_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        logic arb_go;
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        arb_go  = 1'b0;

        if (state_q == S_IDLE) begin
            if (|req) begin
                arb_go = 1'b1;
            end
        end else begin
            if (!req[idx_q]) begin
                // Grantee released: hand over on the same edge if possible.
                if (|req) begin
                    arb_go = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    idx_d   = '0;
                    hold_d  = '0;
                end
            end else if (!hold_expired) begin
                hold_d = (MAX_HOLD == 0) ? '0 : hold_q + 1'b1;
            end else if (|arb_cand) begin
                arb_go = 1'b1;
            end else begin
                // Nobody else waiting: start a fresh tenure for the same grantee.
                hold_d = '0;
            end
        end

        if (arb_go) begin
            state_d          = S_BUSY;
            ptr_d            = arb_idx;
            hold_d           = '0;
            grant_d          = '0;
            grant_d[arb_idx] = 1'b1;
            valid_d          = 1'b1;
            idx_d            = arb_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
module tb_rr_arbiter_n;

    localparam int N = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = '0;
    logic       rr_en = 1'b0;

    logic [3:0] grant0, grant1, grant2;
    logic       v0, v1, v2;
    logic [1:0] i0, i1, i2;

    always #5 clk = ~clk;

    // Three arbiters share the stimulus: MAX_HOLD = 3, 1 and 0 (unlimited).
    rr_arbiter_n #(.N(N), .MAX_HOLD(3)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
        .grant(grant0), .grant_valid(v0), .grant_idx(i0));
    rr_arbiter_n #(.N(N), .MAX_HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
        .grant(grant1), .grant_valid(v1), .grant_idx(i1));
    rr_arbiter_n #(.N(N), .MAX_HOLD(0)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
        .grant(grant2), .grant_valid(v2), .grant_idx(i2));

    logic [2:0][3:0] g_a;
    logic [2:0]      v_a;
    logic [2:0][1:0] i_a;
    assign g_a[0] = grant0;  assign g_a[1] = grant1;  assign g_a[2] = grant2;
    assign v_a[0] = v0;      assign v_a[1] = v1;      assign v_a[2] = v2;
    assign i_a[0] = i0;      assign i_a[1] = i1;      assign i_a[2] = i2;

    typedef struct packed {
        logic            rst;   // rst_n as sampled
        logic            rr;
        logic [3:0]      req;
        logic [2:0][3:0] g;
        logic [2:0][1:0] idx;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // ---------------- reference model ----------------
    int cur[3];    // current grantee, -1 when idle
    int ten[3];    // cycles the current grantee has held in this tenure
    int lastw[3];  // last winner (round-robin reference)

    function automatic int hlim(input int m);
        return (m == 0) ? 3 : ((m == 1) ? 1 : 0);
    endfunction

    function automatic int pick(input logic [3:0] c, input logic rr, input int lst);
        int w;
        int j;
        w = -1;
        if (!rr) begin
            for (int i = 0; i < N; i++) if (c[i]) w = i;
        end else begin
            for (int k = 1; k <= N; k++) begin
                j = (lst - k + N) % N;
                if (w < 0 && c[j]) w = j;
            end
        end
        return w;
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic model_step(input int m);
        logic [3:0] oth;
        int h;
        h = hlim(m);
        if (!rst_n) begin
            cur[m] = -1; ten[m] = 0; lastw[m] = 0;
        end else if (cur[m] < 0) begin
            if (req != 0) begin
                cur[m] = pick(req, rr_en, lastw[m]); lastw[m] = cur[m]; ten[m] = 1;
            end
        end else if (!req[cur[m]]) begin
            if (req != 0) begin
                cur[m] = pick(req, rr_en, lastw[m]); lastw[m] = cur[m]; ten[m] = 1;
            end else begin
                cur[m] = -1;
            end
        end else if (h == 0 || ten[m] < h) begin
            ten[m]++;
        end else begin
            oth = req;
            oth[cur[m]] = 1'b0;
            if (oth != 0) begin
                cur[m] = pick(oth, rr_en, lastw[m]); lastw[m] = cur[m]; ten[m] = 1;
            end else begin
                ten[m] = 1;
            end
        end
    endtask

    // Predictor: every rising edge pushes the expected post-edge outputs.
    initial begin
        exp_t e;
        for (int m = 0; m < 3; m++) begin cur[m] = -1; ten[m] = 0; lastw[m] = 0; end
        forever begin
            @(posedge clk);
            e     = '0;
            e.rst = rst_n;
            e.rr  = rr_en;
            e.req = req;
            for (int m = 0; m < 3; m++) begin
                model_step(m);
                if (cur[m] >= 0) begin
                    e.g[m]   = 4'b0001 << cur[m];
                    e.idx[m] = 2'(cur[m]);
                end
            end
            sb.push_back(e);
        end
    end

    // Monitor: compares on the falling edge, away from the sampling edge.
    initial begin
        exp_t e;
        int   waitc [2][4];
        int   bound;
        logic starve;
        for (int m = 0; m < 2; m++) for (int i = 0; i < N; i++) waitc[m][i] = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int m = 0; m < 3; m++) begin
                    checks++;
                    if (g_a[m] !== e.g[m] || i_a[m] !== e.idx[m] || v_a[m] !== (e.g[m] != 0)) begin
                        failures++;
                        $display("FAIL sb inst%0d t=%0t req=%b rr=%b grant=%b idx=%0d valid=%b expected grant=%b idx=%0d valid=%b",
                                 m, $time, e.req, e.rr, g_a[m], i_a[m], v_a[m], e.g[m], e.idx[m], (e.g[m] != 0));
                    end
                    checks++;
                    if (!$onehot0(g_a[m])) begin
                        failures++;
                        $display("FAIL onehot inst%0d t=%0t grant=%b expected one-hot or zero", m, $time, g_a[m]);
                    end
                end
                for (int m = 0; m < 2; m++) begin
                    bound  = (N - 1) * hlim(m);
                    starve = 1'b0;
                    for (int i = 0; i < N; i++) begin
                        if (!e.rst || !e.rr || !e.req[i] || g_a[m][i]) waitc[m][i] = 0;
                        else waitc[m][i]++;
                        if (waitc[m][i] > bound) starve = 1'b1;
                    end
                    if (e.rst && e.rr) begin
                        checks++;
                        if (starve) begin
                            failures++;
                            $display("FAIL starvation inst%0d t=%0t waits=%0d,%0d,%0d,%0d required<=%0d",
                                     m, $time, waitc[m][0], waitc[m][1], waitc[m][2], waitc[m][3], bound);
                        end
                    end
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input int m, input logic [3:0] eg);
        logic [1:0] ei;
        ei = enc(eg);
        checks++;
        if (g_a[m] !== eg || i_a[m] !== ei || v_a[m] !== (eg != 0)) begin
            failures++;
            $display("FAIL %s inst%0d grant=%b idx=%0d valid=%b expected grant=%b idx=%0d",
                     nm, m, g_a[m], i_a[m], v_a[m], eg, ei);
        end else begin
            $display("ok   %s inst%0d grant=%b idx=%0d", nm, m, g_a[m], i_a[m]);
        end
    endtask

    // Asserts reset between edges, optionally checks outputs cleared before
    // any clock edge, then releases reset on a falling edge with req = 0.
    task automatic apply_reset(input bit check_now);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        if (check_now) for (int m = 0; m < 3; m++) chk("async_reset", m, 4'b0000);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] s3 [5];
        logic [3:0] s4 [7];

        // Power-on reset, then a grant in progress.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rr_en = 1'b0;
        req   = 4'b0110;
        repeat (3) @(negedge clk);
        chk("pre_reset_grant", 0, 4'b0100);

        // 1. asynchronous reset mid-grant, then idle with req = 0
        apply_reset(1'b1);
        repeat (3) @(negedge clk);
        for (int m = 0; m < 3; m++) chk("idle_after_reset", m, 4'b0000);

        // 2. fixed priority and release handover
        rr_en = 1'b0;
        req   = 4'b0110;
        @(negedge clk);
        chk("fixed_0110", 0, 4'b0100);
        req = 4'b0010;
        @(negedge clk);
        chk("fixed_drop2", 0, 4'b0010);

        // 3. round-robin rotation with MAX_HOLD = 1
        apply_reset(1'b0);
        s3 = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        rr_en = 1'b1;
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_rotate", 1, s3[k]);
        end

        // 4. hold expiry with MAX_HOLD = 3, then a lone requester
        apply_reset(1'b0);
        s4 = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b1000};
        rr_en = 1'b1;
        req   = 4'b1001;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("hold_expiry", 0, s4[k]);
        end
        req = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("lone_hold", 0, 4'b1000);
        end

        // 5. unlimited hold, mode toggle mid-tenure, then release
        apply_reset(1'b0);
        rr_en = 1'b0;
        req   = 4'b0011;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("unlimited_hold", 2, 4'b0010);
            if (k == 9) rr_en = 1'b1;
        end
        req = 4'b0001;
        @(negedge clk);
        chk("unlimited_release", 2, 4'b0001);

        // 6a. random traffic, mode changes now and then
        apply_reset(1'b0);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++) if ($urandom_range(0, 4) == 0) req[b] = ~req[b];
            if (c % 37 == 0) rr_en = 1'($urandom_range(0, 1));
        end

        // 6b. random traffic in round-robin mode (starvation bound active)
        apply_reset(1'b1);
        rr_en = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
        end

        req = '0;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
